pll_lock_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/pll_lock_sync.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock supervisor / reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int RETRY_W = 4;
  localparam logic [RETRY_W-1:0] RETRY_SAT = 4'd15;

  // Width able to hold max_val-1 with one bit of headroom.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser for one asynchronous PLL LOCK bit.
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw lock level through the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Lock supervisor and ordered reset releaser for N_PLL PLLs, clocked by the
// board reference clock. Retries on lock loss / timeout, latches a fault
// after MAX_RETRY consecutive failures.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int N_PLL              = 2,
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int RELEASE_GAP        = 8,
  parameter int MAX_RETRY          = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PLL-1:0]   lock_in,
  output logic [N_PLL-1:0]   pll_rst,
  output logic [N_PLL-1:0]   domain_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               fault
);

  localparam int RST_W = cnt_width(PLL_RST_CYCLES);
  localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int TMO_W = cnt_width(LOCK_TIMEOUT);
  localparam int GAP_W = cnt_width(RELEASE_GAP);

  localparam logic [RST_W-1:0]   RST_LAST    = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_W-1:0]   STB_LAST    = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(RELEASE_GAP - 1);
  localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);
  localparam logic               SINGLE_PLL  = (N_PLL == 1);

  pll_state_e          state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0]    stable_q, stable_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [N_PLL-1:0]    pll_rst_q, pll_rst_d;
  logic [N_PLL-1:0]    domain_rst_q, domain_rst_d;
  logic                ready_q, ready_d;
  logic                lock_lost_q, lock_lost_d;
  logic                fault_q, fault_d;

  logic [N_PLL-1:0]    lock_sync_s;
  logic                all_locked_s;
  logic [RETRY_W-1:0]  retry_inc_s;
  logic                retry_exhausted_s;
  logic                gap_done_s;
  logic [N_PLL-1:0]    release_shift_s;

  for (genvar g = 0; g < N_PLL; g++) begin : g_sync
    pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i   (clk),
      .rst_i   (rst),
      .async_i (lock_in[g]),
      .sync_o  (lock_sync_s[g])
    );
  end

  assign all_locked_s      = &lock_sync_s;
  assign retry_inc_s       = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);
  assign retry_exhausted_s = (retry_inc_s >= MAX_RETRY_V);
  assign gap_done_s        = SINGLE_PLL || (gap_q == GAP_LAST);
  // Zeros shift in from bit 0, so domains come out of reset lowest index first.
  assign release_shift_s   = domain_rst_q << 1;

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PLL_RST;
      rst_cnt_q    <= {RST_W{1'b0}};
      stable_q     <= {STB_W{1'b0}};
      tmo_q        <= {TMO_W{1'b0}};
      gap_q        <= {GAP_W{1'b0}};
      retry_q      <= {RETRY_W{1'b0}};
      pll_rst_q    <= {N_PLL{1'b1}};
      domain_rst_q <= {N_PLL{1'b1}};
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stable_q     <= stable_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state and counter logic; counters idle at zero outside their state.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = {RST_W{1'b0}};
    stable_d  = {STB_W{1'b0}};
    tmo_d     = {TMO_W{1'b0}};
    gap_d     = {GAP_W{1'b0}};
    retry_d   = retry_q;
    case (state_q)
      PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      WAIT_LOCK: begin
        // A stable lock takes priority over a coincident timeout.
        if (all_locked_s && (stable_q == STB_LAST)) begin
          state_d = RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          retry_d = retry_inc_s;
          state_d = retry_exhausted_s ? FAULT : PLL_RST;
        end else begin
          tmo_d    = tmo_q + TMO_W'(1);
          stable_d = all_locked_s ? stable_q + STB_W'(1) : {STB_W{1'b0}};
        end
      end
      RELEASE: begin
        // Lock loss abandons a partially completed release.
        if (!all_locked_s) begin
          retry_d = retry_inc_s;
          state_d = retry_exhausted_s ? FAULT : PLL_RST;
        end else if (gap_done_s) begin
          if (release_shift_s == {N_PLL{1'b0}}) begin
            state_d = RUN;
            retry_d = {RETRY_W{1'b0}};
          end else begin
            state_d = RELEASE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      RUN: begin
        if (!all_locked_s) begin
          retry_d = retry_inc_s;
          state_d = retry_exhausted_s ? FAULT : PLL_RST;
        end else begin
          state_d = RUN;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PLL_RST;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    pll_rst_d    = {N_PLL{1'b1}};
    domain_rst_d = {N_PLL{1'b1}};
    ready_d      = 1'b0;
    fault_d      = 1'b0;
    lock_lost_d  = ((state_q == RELEASE) || (state_q == RUN)) && !all_locked_s;
    case (state_d)
      PLL_RST: begin
        pll_rst_d    = {N_PLL{1'b1}};
        domain_rst_d = {N_PLL{1'b1}};
      end
      WAIT_LOCK: begin
        pll_rst_d    = {N_PLL{1'b0}};
        domain_rst_d = {N_PLL{1'b1}};
      end
      RELEASE: begin
        pll_rst_d = {N_PLL{1'b0}};
        if ((state_q == RELEASE) && !gap_done_s) begin
          domain_rst_d = domain_rst_q;
        end else begin
          domain_rst_d = release_shift_s;
        end
      end
      RUN: begin
        pll_rst_d    = {N_PLL{1'b0}};
        domain_rst_d = {N_PLL{1'b0}};
        ready_d      = 1'b1;
      end
      FAULT: begin
        pll_rst_d    = {N_PLL{1'b1}};
        domain_rst_d = {N_PLL{1'b1}};
        fault_d      = 1'b1;
      end
      default: begin
        pll_rst_d    = {N_PLL{1'b1}};
        domain_rst_d = {N_PLL{1'b1}};
      end
    endcase
  end

  assign pll_rst    = pll_rst_q;
  assign domain_rst = domain_rst_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign retry_cnt  = retry_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: each scenario queues the output changes it expects
// (snapshot plus clock edges since the scenario mark); the monitor pops an
// entry on every observed output change and compares it.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] lock_in;
  logic [1:0] pll_rst;
  logic [1:0] domain_rst;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;
  logic       fault;

  pll_lock_sequencer #(
    .N_PLL              (2),
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT       (64),
    .RELEASE_GAP        (3),
    .MAX_RETRY          (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock_in    (lock_in),
    .pll_rst    (pll_rst),
    .domain_rst (domain_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] exp_snap_q[$];
  int          exp_dly_q[$];
  string       exp_name_q[$];

  int          mark_cyc = 0;
  int          deadline_cyc = 0;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [10:0] prev_snap;
  bit          prev_valid = 1'b0;
  logic [10:0] cur_snap;
  logic [10:0] es;
  int          ed;
  string       en;

  // snapshot = {pll_rst, domain_rst, ready, lock_lost, retry_cnt, fault}
  function automatic logic [10:0] mk(input logic [1:0] p, input logic [1:0] d,
                                     input logic r, input logic l,
                                     input logic [3:0] rc, input logic f);
    return {p, d, r, l, rc, f};
  endfunction

  localparam logic [10:0] RST_SNAP = {2'b11, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0};

  // Monitor: compare every output change against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur_snap = {pll_rst, domain_rst, ready, lock_lost, retry_cnt, fault};
        if (!prev_valid || (cur_snap !== prev_snap)) begin
          prev_valid = 1'b1;
          prev_snap  = cur_snap;
          checks++;
          if (exp_snap_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change: got %b at +%0d, want no change",
                     cur_snap, cyc - mark_cyc);
          end else begin
            es = exp_snap_q.pop_front();
            ed = exp_dly_q.pop_front();
            en = exp_name_q.pop_front();
            if ((cur_snap !== es) || ((cyc - mark_cyc) != ed)) begin
              failures++;
              $display("FAIL %s: got %b at +%0d, want %b at +%0d",
                       en, cur_snap, cyc - mark_cyc, es, ed);
            end
          end
        end else if ((exp_snap_q.size() != 0) && (cyc > deadline_cyc)) begin
          es = exp_snap_q.pop_front();
          ed = exp_dly_q.pop_front();
          en = exp_name_q.pop_front();
          checks++;
          failures++;
          $display("FAIL %s: no change by +%0d, got %b, want %b at +%0d",
                   en, cyc - mark_cyc, cur_snap, es, ed);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_ev(input string nm, input int d, input logic [10:0] s);
    exp_snap_q.push_back(s);
    exp_dly_q.push_back(d);
    exp_name_q.push_back(nm);
    deadline_cyc = mark_cyc + d + 4;
  endtask

  task automatic wait_to(input int d);
    while ((cyc - mark_cyc) < d) step();
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_snap_q.size() != 0) && (guard < 500)) begin
      step();
      guard++;
    end
    if (exp_snap_q.size() != 0) begin
      $display("FAIL drain_stuck: got %0d pending, want 0", exp_snap_q.size());
      $fatal(1);
    end
  endtask

  task automatic rst_pulse(input logic [1:0] lk);
    step();
    rst      = 1'b1;
    lock_in  = lk;
    mark_cyc = cyc;
    expect_ev("rst_pulse", 1, RST_SNAP);
    step();
    rst = 1'b0;
  endtask

  // Directed scenarios with hand-computed output change timings.
  initial begin
    rst     = 1'b1;
    lock_in = 2'b11;
    repeat (3) step();
    mark_cyc = cyc;
    expect_ev("reset_state", 0, RST_SNAP);
    mon_en = 1'b1;

    // Clean bring-up
    step();
    rst      = 1'b0;
    mark_cyc = cyc;
    expect_ev("s1_pll_release", 4,  mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s1_dom0",        12, mk(2'b00, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s1_ready",       15, mk(2'b00, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0));
    drain();
    repeat (5) step();

    // Lock loss in RUN, then re-lock
    lock_in  = 2'b10;
    mark_cyc = cyc;
    expect_ev("s3_loss",        3,  mk(2'b11, 2'b11, 1'b0, 1'b1, 4'd1, 1'b0));
    expect_ev("s3_pulse_end",   4,  mk(2'b11, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_ev("s3_pll_release", 7,  mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_ev("s3_dom0",        15, mk(2'b00, 2'b10, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_ev("s3_ready",       18, mk(2'b00, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0));
    wait_to(5);
    lock_in = 2'b11;
    drain();
    repeat (5) step();

    // Glitch on lock bit 1 while the stable counter is at 5
    rst_pulse(2'b11);
    expect_ev("s2_pll_release", 5,  mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s2_dom0",        19, mk(2'b00, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s2_ready",       22, mk(2'b00, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0));
    wait_to(8);
    lock_in = 2'b01;
    step();
    lock_in = 2'b11;
    drain();
    repeat (5) step();

    // Lock loss part-way through the release
    rst_pulse(2'b11);
    expect_ev("s5_pll_release", 5,  mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s5_dom0",        13, mk(2'b00, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s5_loss",        16, mk(2'b11, 2'b11, 1'b0, 1'b1, 4'd1, 1'b0));
    expect_ev("s5_pulse_end",   17, mk(2'b11, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_ev("s5_rewait",      20, mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0));
    wait_to(13);
    lock_in = 2'b01;
    drain();
    wait_to(40);

    // Repeated lock timeouts end in FAULT
    rst_pulse(2'b01);
    expect_ev("s4_pll_release", 5,   mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s4_timeout1",    69,  mk(2'b11, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_ev("s4_rewait1",     73,  mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd1, 1'b0));
    expect_ev("s4_timeout2",    137, mk(2'b11, 2'b11, 1'b0, 1'b0, 4'd2, 1'b0));
    expect_ev("s4_rewait2",     141, mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd2, 1'b0));
    expect_ev("s4_fault",       205, mk(2'b11, 2'b11, 1'b0, 1'b0, 4'd3, 1'b1));
    drain();
    wait_to(300);

    // Reset out of FAULT followed by a normal bring-up
    rst_pulse(2'b11);
    expect_ev("s6_pll_release", 5,  mk(2'b00, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s6_dom0",        13, mk(2'b00, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0));
    expect_ev("s6_ready",       16, mk(2'b00, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0));
    drain();
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, want finish before 100000");
    $fatal(1);
  end

endmodule
